// File: rtl/pipeline_latch_bank.sv
// rtl/pipeline_latch_bank.sv - FD/DE/EM/MW inter-stage registers with halt, drain and debug counters
module pipeline_latch_bank #(
    parameter int FD_W  = 64,
    parameter int DE_W  = 128,
    parameter int EM_W  = 128,
    parameter int MW_W  = 96,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             fd_en_i,
    input  logic             de_en_i,
    input  logic             em_en_i,
    input  logic             mw_en_i,
    input  logic             fd_flush_i,
    input  logic             de_flush_i,
    input  logic             em_flush_i,
    input  logic             mw_flush_i,
    input  logic [FD_W-1:0]  fd_d_i,
    input  logic             fd_vld_in_i,
    input  logic [DE_W-1:0]  de_d_i,
    input  logic [EM_W-1:0]  em_d_i,
    input  logic [MW_W-1:0]  mw_d_i,
    input  logic             halt_dec_i,
    output logic [FD_W-1:0]  fd_q_o,
    output logic [DE_W-1:0]  de_q_o,
    output logic [EM_W-1:0]  em_q_o,
    output logic [MW_W-1:0]  mw_q_o,
    output logic             fd_vld_o,
    output logic             de_vld_o,
    output logic             em_vld_o,
    output logic             mw_vld_o,
    output logic             halt_out_o,
    output logic             drained_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    logic [FD_W-1:0]  fd_q_q, fd_q_d;
    logic [DE_W-1:0]  de_q_q, de_q_d;
    logic [EM_W-1:0]  em_q_q, em_q_d;
    logic [MW_W-1:0]  mw_q_q, mw_q_d;
    logic             fd_vld_q, fd_vld_d, de_vld_q, de_vld_d;
    logic             em_vld_q, em_vld_d, mw_vld_q, mw_vld_d;
    logic             de_h_q, de_h_d, em_h_q, em_h_d, mw_h_q, mw_h_d;
    logic             halt_q, halt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic             stall_evt, flush_evt;

    // A retired HALT freezes every load; flushes still apply.
    always_comb begin
        fd_q_d   = fd_q_q;   fd_vld_d = fd_vld_q;
        de_q_d   = de_q_q;   de_vld_d = de_vld_q;  de_h_d = de_h_q;
        em_q_d   = em_q_q;   em_vld_d = em_vld_q;  em_h_d = em_h_q;
        mw_q_d   = mw_q_q;   mw_vld_d = mw_vld_q;  mw_h_d = mw_h_q;

        if (fd_flush_i) begin
            fd_q_d = '0; fd_vld_d = 1'b0;
        end else if (fd_en_i && !halt_q) begin
            fd_q_d = fd_d_i; fd_vld_d = fd_vld_in_i;
        end

        if (de_flush_i) begin
            de_q_d = '0; de_vld_d = 1'b0; de_h_d = 1'b0;
        end else if (de_en_i && !halt_q) begin
            de_q_d = de_d_i; de_vld_d = fd_vld_q; de_h_d = halt_dec_i & fd_vld_q;
        end

        if (em_flush_i) begin
            em_q_d = '0; em_vld_d = 1'b0; em_h_d = 1'b0;
        end else if (em_en_i && !halt_q) begin
            em_q_d = em_d_i; em_vld_d = de_vld_q; em_h_d = de_h_q;
        end

        if (mw_flush_i) begin
            mw_q_d = '0; mw_vld_d = 1'b0; mw_h_d = 1'b0;
        end else if (mw_en_i && !halt_q) begin
            mw_q_d = mw_d_i; mw_vld_d = em_vld_q; mw_h_d = em_h_q;
        end
    end

    assign halt_d    = halt_q | (mw_h_q & mw_vld_q);
    assign stall_evt = !halt_q && ((!fd_en_i && !fd_flush_i) || (!de_en_i && !de_flush_i));
    assign flush_evt = !halt_q && (fd_flush_i || de_flush_i);

    // Both counters saturate at all-ones instead of wrapping.
    assign stall_cnt_d = (stall_evt && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    assign flush_cnt_d = (flush_evt && !(&flush_cnt_q)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fd_q_q <= '0; de_q_q <= '0; em_q_q <= '0; mw_q_q <= '0;
            fd_vld_q <= 1'b0; de_vld_q <= 1'b0; em_vld_q <= 1'b0; mw_vld_q <= 1'b0;
            de_h_q <= 1'b0; em_h_q <= 1'b0; mw_h_q <= 1'b0;
            halt_q <= 1'b0;
            stall_cnt_q <= '0; flush_cnt_q <= '0;
        end else begin
            fd_q_q <= fd_q_d; de_q_q <= de_q_d; em_q_q <= em_q_d; mw_q_q <= mw_q_d;
            fd_vld_q <= fd_vld_d; de_vld_q <= de_vld_d;
            em_vld_q <= em_vld_d; mw_vld_q <= mw_vld_d;
            de_h_q <= de_h_d; em_h_q <= em_h_d; mw_h_q <= mw_h_d;
            halt_q <= halt_d;
            stall_cnt_q <= stall_cnt_d; flush_cnt_q <= flush_cnt_d;
        end
    end

    assign fd_q_o      = fd_q_q;
    assign de_q_o      = de_q_q;
    assign em_q_o      = em_q_q;
    assign mw_q_o      = mw_q_q;
    assign fd_vld_o    = fd_vld_q;
    assign de_vld_o    = de_vld_q;
    assign em_vld_o    = em_vld_q;
    assign mw_vld_o    = mw_vld_q;
    assign halt_out_o  = halt_q;
    assign drained_o   = !(fd_vld_q || de_vld_q || em_vld_q || mw_vld_q);
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_latch_bank.sv
// tb/tb_pipeline_latch_bank.sv - scoreboard bench for pipeline_latch_bank
module tb_pipeline_latch_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, fd_en, de_en, em_en, mw_en, fd_fl, de_fl, em_fl, mw_fl;
    logic [63:0]  fd_d;
    logic [127:0] de_d, em_d;
    logic [95:0]  mw_d;
    logic fd_vld_in, halt_dec;
    logic [63:0]  fd_q;
    logic [127:0] de_q, em_q;
    logic [95:0]  mw_q;
    logic fd_vld, de_vld, em_vld, mw_vld, halt_out, drained;
    logic [3:0] stall_cnt, flush_cnt;

    pipeline_latch_bank #(.FD_W(64), .DE_W(128), .EM_W(128), .MW_W(96), .CNT_W(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .fd_en_i(fd_en), .de_en_i(de_en), .em_en_i(em_en), .mw_en_i(mw_en),
        .fd_flush_i(fd_fl), .de_flush_i(de_fl), .em_flush_i(em_fl), .mw_flush_i(mw_fl),
        .fd_d_i(fd_d), .fd_vld_in_i(fd_vld_in), .de_d_i(de_d), .em_d_i(em_d), .mw_d_i(mw_d),
        .halt_dec_i(halt_dec),
        .fd_q_o(fd_q), .de_q_o(de_q), .em_q_o(em_q), .mw_q_o(mw_q),
        .fd_vld_o(fd_vld), .de_vld_o(de_vld), .em_vld_o(em_vld), .mw_vld_o(mw_vld),
        .halt_out_o(halt_out), .drained_o(drained),
        .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    typedef struct {
        logic [63:0]  fd_q;  logic fd_v;
        logic [127:0] de_q;  logic de_v; logic de_h;
        logic [127:0] em_q;  logic em_v; logic em_h;
        logic [95:0]  mw_q;  logic mw_v; logic mw_h;
        logic halt;
        logic [3:0] stall, flush;
    } st_t;

    st_t m;
    st_t sb[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference behaviour for one clock edge, then queue the expected result.
    task automatic step();
        st_t n;
        n = m;
        if (rst) begin
            n = '{default: '0};
        end else begin
            if (fd_fl) begin n.fd_q = '0; n.fd_v = 0; end
            else if (fd_en && !m.halt) begin n.fd_q = fd_d; n.fd_v = fd_vld_in; end
            if (de_fl) begin n.de_q = '0; n.de_v = 0; n.de_h = 0; end
            else if (de_en && !m.halt) begin n.de_q = de_d; n.de_v = m.fd_v; n.de_h = halt_dec && m.fd_v; end
            if (em_fl) begin n.em_q = '0; n.em_v = 0; n.em_h = 0; end
            else if (em_en && !m.halt) begin n.em_q = em_d; n.em_v = m.de_v; n.em_h = m.de_h; end
            if (mw_fl) begin n.mw_q = '0; n.mw_v = 0; n.mw_h = 0; end
            else if (mw_en && !m.halt) begin n.mw_q = mw_d; n.mw_v = m.em_v; n.mw_h = m.em_h; end
            if (m.mw_h && m.mw_v) n.halt = 1;
            if (!m.halt && ((!fd_en && !fd_fl) || (!de_en && !de_fl)) && m.stall != 4'hF)
                n.stall = m.stall + 4'd1;
            if (!m.halt && (fd_fl || de_fl) && m.flush != 4'hF)
                n.flush = m.flush + 4'd1;
        end
        m = n;
        sb.push_back(n);
        @(posedge clk);
        #2;
    endtask

    task automatic steps(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    initial begin : monitor
        st_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("fd", {fd_vld, fd_q}, {e.fd_v, e.fd_q});
                chk("de", {de_vld, de_q}, {e.de_v, e.de_q});
                chk("em", {em_vld, em_q}, {e.em_v, e.em_q});
                chk("mw", {mw_vld, mw_q}, {e.mw_v, e.mw_q});
                chk("halt_drained", {halt_out, drained},
                    {e.halt, !(e.fd_v || e.de_v || e.em_v || e.mw_v)});
                chk("counters", {stall_cnt, flush_cnt}, {e.stall, e.flush});
            end
        end
    end

    initial begin : driver
        int wait_cyc;
        m = '{default: '0};
        rst = 1; {fd_en, de_en, em_en, mw_en} = 4'hF; {fd_fl, de_fl, em_fl, mw_fl} = 4'h0;
        fd_d = 64'h1234; fd_vld_in = 1; halt_dec = 0;
        de_d = 128'hDE00; em_d = 128'hE300; mw_d = 96'h3300;

        // Reset dominates enables and valid input
        steps(2);
        chk("t1_drained", drained, 1'b1);
        chk("t1_counts", {stall_cnt, flush_cnt}, 8'h00);

        // Single valid token walks the pipe
        rst = 0; fd_d = 64'hA; fd_vld_in = 1;
        step();
        chk("t2_fd_edge1", {fd_vld, fd_q}, {1'b1, 64'hA});
        fd_vld_in = 0; fd_d = 64'h0;
        steps(2);
        chk("t2_mw_edge3", mw_vld, 1'b0);
        step();
        chk("t2_mw_edge4", mw_vld, 1'b1);
        step();
        chk("t2_drained_edge5", {mw_vld, drained}, 2'b01);
        steps(1);

        // DE stall with EM load-use bubble
        fd_vld_in = 1;
        fd_d = 64'h1; de_d = 128'hD1; em_d = 128'hE1; mw_d = 96'hF1; step();
        fd_d = 64'h2; de_d = 128'hD2; em_d = 128'hE2; mw_d = 96'hF2; step();
        fd_d = 64'h3; de_d = 128'hD3; em_d = 128'hE3; mw_d = 96'hF3; step();
        de_en = 0; em_fl = 1; de_d = 128'hD4; step();
        chk("t3_de_held", de_q, 128'hD3);
        chk("t3_em_bubble", {em_vld, em_q}, 129'h0);
        chk("t3_counts", {stall_cnt, flush_cnt}, 8'h10);
        de_en = 1; em_fl = 0; fd_vld_in = 0;
        steps(5);

        // Flush beats enable on FD
        fd_en = 1; fd_fl = 1; fd_d = 64'hDEAD; fd_vld_in = 1;
        step();
        chk("t4_fd_flush", {fd_vld, fd_q}, 65'h0);
        chk("t4_flush_cnt", flush_cnt, 4'h1);
        fd_fl = 0;

        // HALT retirement and freeze
        rst = 1; step(); rst = 0;
        fd_d = 64'h51; step();
        fd_d = 64'h52; halt_dec = 1; step();
        halt_dec = 0;
        fd_d = 64'h53; step();
        fd_d = 64'h54; step();
        chk("t5_halt_not_yet", halt_out, 1'b0);
        fd_d = 64'h55; step();
        chk("t5_halt_set", halt_out, 1'b1);
        fd_d = 64'hBEEF; de_en = 0;
        steps(3);
        chk("t5_fd_frozen", fd_q, 64'h55);
        chk("t5_cnt_frozen", {stall_cnt, halt_out}, 5'b0000_1);
        em_fl = 1; step(); em_fl = 0;
        chk("t5_flush_while_halted", em_vld, 1'b0);
        de_en = 1; rst = 1; step(); rst = 0;
        chk("t5_rst_clears_halt", halt_out, 1'b0);

        // Counter saturation
        fd_vld_in = 0; de_en = 0;
        steps(20);
        chk("t6_stall_sat", {stall_cnt, flush_cnt}, 8'hF0);
        de_en = 1; fd_fl = 1;
        steps(20);
        chk("t6_flush_sat", {stall_cnt, flush_cnt}, 8'hFF);
        fd_fl = 0;

        wait_cyc = 0;
        while (sb.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        #3;
        chk("scoreboard_drained", 256'(sb.size()), 256'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
